// File: rtl/morse_round_judge_if.sv
// Handshake bundle between the Morse accumulators / display and the round judge.
// master: upstream side driving start, tick, player codes and submits.
// slave : the judge, returning clr_codes and the game/round status outputs.
interface morse_round_judge_if #(
    parameter int unsigned CODE_W  = 10,
    parameter int unsigned SCORE_W = 4
);
    logic               start;
    logic               tick;
    logic [CODE_W-1:0]  p1_code;
    logic               p1_submit;
    logic [CODE_W-1:0]  p2_code;
    logic               p2_submit;
    logic               clr_codes;
    logic [2:0]         state;
    logic [3:0]         round_num;
    logic [5:0]         secs_left;
    logic [2:0]         tries;
    logic               match;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               game_over;
    logic [1:0]         winner;

    modport master (
        output start, tick, p1_code, p1_submit, p2_code, p2_submit,
        input  clr_codes, state, round_num, secs_left, tries, match,
               p1_score, p2_score, game_over, winner
    );

    modport slave (
        input  start, tick, p1_code, p1_submit, p2_code, p2_submit,
        output clr_codes, state, round_num, secs_left, tries, match,
               p1_score, p2_score, game_over, winner
    );
endinterface

// File: rtl/morse_round_judge.sv
// Game-control stage behind the two per-player Morse accumulators.
// Player 1 locks a secret code, player 2 must reproduce it within a tick
// budget and a try limit; rounds are scored, sequenced, and a clear pulse
// is returned to the accumulators.
// Ports: clock, resetn (synchronous, active-low), bus (slave modport:
// start/tick/codes/submits in; clr_codes, state, round_num, secs_left,
// tries, match, scores, game_over, winner out). All outputs registered.
module morse_round_judge #(
    parameter int unsigned CODE_W       = 10,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned ROUNDS       = 5,
    parameter int unsigned ROUND_TICKS  = 30,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned RESULT_TICKS = 3
) (
    input logic                 clock,
    input logic                 resetn,
    morse_round_judge_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_ENTRY = 3'd1,
        P2_GUESS = 3'd2,
        RESULT   = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic [5:0]         secs_q, secs_d;
    logic [2:0]         tries_q, tries_d;
    logic               match_q, match_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic               clr_q, clr_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic [CODE_W-1:0]  secret_q, secret_d;
    logic [2:0]         res_cnt_q, res_cnt_d;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        secs_d      = secs_q;
        tries_d     = tries_q;
        match_d     = match_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        clr_d       = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        secret_d    = secret_q;
        res_cnt_d   = res_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = P1_ENTRY;
                    round_d     = 4'd1;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    match_d     = 1'b0;
                    tries_d     = '0;
                    secs_d      = '0;
                    game_over_d = 1'b0;
                    winner_d    = 2'b00;
                    clr_d       = 1'b1;
                end
            end

            P1_ENTRY: begin
                if (bus.p1_submit && bus.p1_code != '0) begin
                    secret_d = bus.p1_code;
                    secs_d   = 6'(ROUND_TICKS);
                    tries_d  = '0;
                    clr_d    = 1'b1;
                    state_d  = P2_GUESS;
                end
            end

            P2_GUESS: begin
                // A non-empty submit outranks a coincident tick, so the timer
                // holds its value on the cycle a guess is judged.
                if (bus.p2_submit && bus.p2_code != '0) begin
                    if (bus.p2_code == secret_q) begin
                        match_d    = 1'b1;
                        p2_score_d = sat_inc(p2_score_q);
                        res_cnt_d  = '0;
                        state_d    = RESULT;
                    end else if (tries_q == 3'(MAX_TRIES - 1)) begin
                        p1_score_d = sat_inc(p1_score_q);
                        res_cnt_d  = '0;
                        state_d    = RESULT;
                    end else begin
                        tries_d = tries_q + 3'd1;
                        clr_d   = 1'b1;
                    end
                end else if (bus.tick) begin
                    if (secs_q <= 6'd1) begin
                        secs_d     = '0;
                        p1_score_d = sat_inc(p1_score_q);
                        res_cnt_d  = '0;
                        state_d    = RESULT;
                    end else begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end

            RESULT: begin
                if (bus.tick) begin
                    if (res_cnt_q == 3'(RESULT_TICKS - 1)) begin
                        if (round_q == 4'(ROUNDS)) begin
                            state_d     = DONE;
                            game_over_d = 1'b1;
                            if (p1_score_q > p2_score_q)
                                winner_d = 2'b01;
                            else if (p2_score_q > p1_score_q)
                                winner_d = 2'b10;
                            else
                                winner_d = 2'b11;
                        end else begin
                            round_d = round_q + 4'd1;
                            match_d = 1'b0;
                            clr_d   = 1'b1;
                            state_d = P1_ENTRY;
                        end
                    end else begin
                        res_cnt_d = res_cnt_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            round_q     <= '0;
            secs_q      <= '0;
            tries_q     <= '0;
            match_q     <= 1'b0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            clr_q       <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= '0;
            secret_q    <= '0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            secs_q      <= secs_d;
            tries_q     <= tries_d;
            match_q     <= match_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            clr_q       <= clr_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            secret_q    <= secret_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.round_num = round_q;
    assign bus.secs_left = secs_q;
    assign bus.tries     = tries_q;
    assign bus.match     = match_q;
    assign bus.p1_score  = p1_score_q;
    assign bus.p2_score  = p2_score_q;
    assign bus.clr_codes = clr_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule
